// File: rtl/instruction_memory_responder_if.sv
// Fetch and program-load bus between basic_block (master) and instruction_memory_responder (slave).
interface instruction_memory_responder_if #(
  parameter int unsigned MEMORY_WIDTH      = 16,
  parameter int unsigned MEMORY_ADDR_WIDTH = 11
);

  logic                         memory_valid;
  logic [MEMORY_ADDR_WIDTH-1:0] memory_addr;
  logic                         memory_ready;
  logic [MEMORY_WIDTH-1:0]      memory_data;

  logic                         load_valid;
  logic [MEMORY_ADDR_WIDTH-1:0] load_addr;
  logic [MEMORY_WIDTH-1:0]      load_data;
  logic                         load_ready;

  modport master (
    output memory_valid, memory_addr, load_valid, load_addr, load_data,
    input  memory_ready, memory_data, load_ready
  );

  modport slave (
    input  memory_valid, memory_addr, load_valid, load_addr, load_data,
    output memory_ready, memory_data, load_ready
  );

endinterface

// File: rtl/instruction_memory_responder.sv
// Instruction RAM responder for the basic_block fetch port, plus a program-load write port.
// Define INSTRUCTION_MEMORY_RESPONDER_OOR_CHECK_EN for the sticky oor_error flag and halt-opcode fill.
module instruction_memory_responder #(
  parameter int unsigned MEMORY_WIDTH      = 16,
  parameter int unsigned MEMORY_ADDR_WIDTH = 11,
  parameter int unsigned MEMORY_DEPTH      = 2048
) (
  input  logic                         clk,
  input  logic                         reset,
  instruction_memory_responder_if.slave bus
`ifdef INSTRUCTION_MEMORY_RESPONDER_OOR_CHECK_EN
  ,
  output logic                         oor_error
`endif
);

  localparam int unsigned IDX_W     = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int unsigned PAYLOAD_W = 8;
  localparam int unsigned OPCODE_W  = MEMORY_WIDTH - PAYLOAD_W;

`ifdef INSTRUCTION_MEMORY_RESPONDER_OOR_CHECK_EN
  // Halt opcode with zero payload so a core fetching off the end stops without accepting.
  localparam logic [OPCODE_W-1:0]     END_WITHOUT_ACCEPTING = OPCODE_W'(1);
  localparam logic [MEMORY_WIDTH-1:0] OOR_WORD = {END_WITHOUT_ACCEPTING, PAYLOAD_W'(0)};
`else
  localparam logic [MEMORY_WIDTH-1:0] OOR_WORD = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_GRANT = 2'd2,
    S_DATA  = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [MEMORY_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                         fetch_oor_q, fetch_oor_d;
  logic                         ready_q, ready_d;
  logic [MEMORY_WIDTH-1:0]      data_q, data_d;
  logic [MEMORY_WIDTH-1:0]      rd_raw_q;
  logic [MEMORY_WIDTH-1:0]      mem_q [MEMORY_DEPTH];

  logic fetch_in_range_c;
  logic load_in_range_c;
  logic fetch_start_c;
  logic load_ready_c;
  logic load_accept_c;
  logic mem_we_c;
  logic mem_re_c;

  // Request decode shared by the FSM, the datapath and the load port.
  always_comb begin
    fetch_in_range_c = 32'(bus.memory_addr) < MEMORY_DEPTH;
    load_in_range_c  = 32'(bus.load_addr) < MEMORY_DEPTH;
    fetch_start_c    = (state_q == S_IDLE) && bus.memory_valid;
    load_ready_c     = (state_q == S_IDLE) && !bus.memory_valid && reset;
    load_accept_c    = bus.load_valid && load_ready_c;
    mem_we_c         = load_accept_c && load_in_range_c;
    mem_re_c         = (state_q == S_READ);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fixed four-state walk; valid is only looked at in IDLE, so a held request cannot re-grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.memory_valid) state_d = S_READ;
      S_READ:  state_d = S_GRANT;
      S_GRANT: state_d = S_DATA;
      S_DATA:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    fetch_oor_d = fetch_oor_q;
    ready_d     = (state_q == S_GRANT);
    data_d      = data_q;
    if (fetch_start_c) begin
      addr_d      = bus.memory_addr;
      fetch_oor_d = !fetch_in_range_c;
    end
    if (state_q == S_DATA) begin
      data_d = fetch_oor_q ? OOR_WORD : rd_raw_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      fetch_oor_q <= 1'b0;
      ready_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      addr_q      <= addr_d;
      fetch_oor_q <= fetch_oor_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
    end
  end

  // Single-port RAM: writes only happen in IDLE and reads only in READ, so they never collide.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[IDX_W'(bus.load_addr)] <= bus.load_data;
    end
    if (mem_re_c) begin
      rd_raw_q <= mem_q[IDX_W'(addr_q)];
    end
  end

`ifdef INSTRUCTION_MEMORY_RESPONDER_OOR_CHECK_EN
  logic oor_q, oor_d;

  always_comb begin
    oor_d = oor_q
          | (fetch_start_c && !fetch_in_range_c)
          | (load_accept_c && !load_in_range_c);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oor_q <= 1'b0;
    end else begin
      oor_q <= oor_d;
    end
  end

  assign oor_error = oor_q;
`endif

  assign bus.memory_ready = ready_q;
  assign bus.memory_data  = data_q;
  assign bus.load_ready   = load_ready_c;

endmodule
